// File: rtl/word_serializer_mux.sv
// word_serializer_mux: accepts WIDTH-bit words on a valid/ready handshake and
// emits them one bit per accepted downstream transfer. down_last marks the
// final bit. A new word may load on the last-bit edge, so back-to-back words
// leave no bubble between them.
module word_serializer_mux #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   output logic             down_valid,
   input  logic             down_ready,
   output logic             down_data,
   output logic             down_last
);

   localparam int IDXW   = $clog2(WIDTH);
   localparam int LEAVES = 1 << IDXW;

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_SHIFT = 1'b1;

   // The first and final bit positions depend on the emission order.
   localparam logic [IDXW-1:0] FIRST_IDX = MSB_FIRST ? IDXW'(WIDTH - 1) : '0;
   localparam logic [IDXW-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDXW'(WIDTH - 1);

   logic             state_q, state_d;
   logic [WIDTH-1:0] word_q,  word_d;
   logic [IDXW-1:0]  idx_q,   idx_d;

   logic sel_bit;
   logic fire_down;
   logic accept_up;

   // WIDTH:1 select tree of 2:1 mux cells, one tree level per idx bit.
   // Leaves above WIDTH-1 are tied to zero, so a non-power-of-2 WIDTH can
   // never route a bit from outside the stored word.
   always_comb begin
      logic [LEAVES-1:0] lvl;
      lvl              = '0;
      lvl[WIDTH-1:0]   = word_q;
      // Each level halves the node count in place: node n is written only
      // after nodes 2n and 2n+1 of the level below have been consumed.
      for (int l = 0; l < IDXW; l++) begin
         for (int n = 0; n < (LEAVES >> (l + 1)); n++) begin
            lvl[n] = idx_q[l] ? lvl[2*n+1] : lvl[2*n];
         end
      end
      sel_bit = lvl[0];
   end

   // Output decode and next-state logic.
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;

      down_valid = (state_q == STATE_SHIFT);
      down_data  = down_valid & sel_bit;
      down_last  = down_valid && (idx_q == LAST_IDX);

      fire_down = down_valid && down_ready;
      // Depends only on state and down_ready, never on up_valid.
      up_ready  = (state_q == STATE_IDLE) || (fire_down && down_last);
      accept_up = up_valid && up_ready;

      if (fire_down) begin
         if (down_last) begin
            state_d = STATE_IDLE;
         end else if (MSB_FIRST) begin
            idx_d = idx_q - IDXW'(1);
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end

      // A word accepted on the last-bit edge overrides the return to IDLE.
      if (accept_up) begin
         word_d  = up_data;
         idx_d   = FIRST_IDX;
         state_d = STATE_SHIFT;
      end
   end

   // State, word and bit-counter registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the word register is reset as well, so the data path leaves
      // reset in a known state even though IDLE masks down_data anyway.
      if (rst) begin
         state_q <= STATE_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the values
         // from before this edge regardless of statement order.
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_word_serializer_mux.sv
// Testbench for word_serializer_mux. One LSB-first and one MSB-first
// instance share the stimulus; both are compared every cycle against a
// queue-of-bits reference model, plus hand-written expectations for the
// corner cases.
module tb_word_serializer_mux;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         up_valid;
   logic [W-1:0] up_data;
   logic         down_ready;

   logic up_ready_l, down_valid_l, down_data_l, down_last_l;
   logic up_ready_m, down_valid_m, down_data_m, down_last_m;

   word_serializer_mux #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready_l),
      .up_data    (up_data),
      .down_valid (down_valid_l),
      .down_ready (down_ready),
      .down_data  (down_data_l),
      .down_last  (down_last_l)
   );

   word_serializer_mux #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready_m),
      .up_data    (up_data),
      .down_valid (down_valid_m),
      .down_ready (down_ready),
      .down_data  (down_data_m),
      .down_last  (down_last_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the bits still owed downstream, in emission order.
   logic q_l[$];
   logic q_m[$];

   // Bits actually handed downstream, reassembled into words.
   logic [W-1:0] got_l = '0;
   logic [W-1:0] got_m = '0;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic         e_valid;
      logic         e_data;
      logic         e_last;
      logic         e_ready;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare both instances with what the model owes, and collect bits.
   task automatic check_model();
      check("l_valid", W'(down_valid_l), W'(q_l.size() != 0));
      check("l_data",  W'(down_data_l),  W'((q_l.size() != 0) ? q_l[0] : 1'b0));
      check("l_last",  W'(down_last_l),  W'(q_l.size() == 1));
      check("l_ready", W'(up_ready_l),   W'((q_l.size() == 0) || (down_ready && q_l.size() == 1)));
      check("m_valid", W'(down_valid_m), W'(q_m.size() != 0));
      check("m_data",  W'(down_data_m),  W'((q_m.size() != 0) ? q_m[0] : 1'b0));
      check("m_last",  W'(down_last_m),  W'(q_m.size() == 1));
      check("m_ready", W'(up_ready_m),   W'((q_m.size() == 0) || (down_ready && q_m.size() == 1)));
      if (down_valid_l && down_ready) got_l = {down_data_l, got_l[W-1:1]};
      if (down_valid_m && down_ready) got_m = {got_m[W-2:0], down_data_m};
   endtask

   // Advance the model across a rising edge using the held inputs.
   task automatic model_update();
      logic rdy_l, rdy_m;
      rdy_l = (q_l.size() == 0) || (down_ready && q_l.size() == 1);
      rdy_m = (q_m.size() == 0) || (down_ready && q_m.size() == 1);
      if (q_l.size() != 0 && down_ready) void'(q_l.pop_front());
      if (q_m.size() != 0 && down_ready) void'(q_m.pop_front());
      if (up_valid && rdy_l) for (int i = 0; i < W; i++) q_l.push_back(up_data[i]);
      if (up_valid && rdy_m) for (int i = W - 1; i >= 0; i--) q_m.push_back(up_data[i]);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
      up_valid   = v;
      up_data    = d;
      down_ready = r;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic r);
      drive(v, d, r);
      @(negedge clk);
      check_model();
      finish_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid_l"}, W'(down_valid_l), '0);
      check({tag, "_data_l"},  W'(down_data_l),  '0);
      check({tag, "_last_l"},  W'(down_last_l),  '0);
      check({tag, "_ready_l"}, W'(up_ready_l),   W'(1));
      check({tag, "_valid_m"}, W'(down_valid_m), '0);
      check({tag, "_ready_m"}, W'(up_ready_m),   W'(1));
   endtask

   initial begin
      // Test 1 vectors: 8'hA5 LSB-first with down_ready held high.
      vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state.
      rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Test 1: table-driven.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].r);
         @(negedge clk);
         check_model();
         check($sformatf("t1_valid[%0d]", i), W'(down_valid_l), W'(vecs[i].e_valid));
         check($sformatf("t1_data[%0d]", i),  W'(down_data_l),  W'(vecs[i].e_data));
         check($sformatf("t1_last[%0d]", i),  W'(down_last_l),  W'(vecs[i].e_last));
         check($sformatf("t1_ready[%0d]", i), W'(up_ready_l),   W'(vecs[i].e_ready));
         finish_cycle();
      end
      check("t1_word_l", got_l, 8'hA5);

      // Test 2: 8'h0F, MSB-first instance emits 0,0,0,0,1,1,1,1.
      step(1'b1, 8'h0F, 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1);
      check("t2_word_m", got_m, 8'h0F);
      check("t2_word_l", got_l, 8'h0F);
      step(1'b0, '0, 1'b1);

      // Test 3: 8'h3C with a 3-cycle stall after the 2nd bit.
      step(1'b1, 8'h3C, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b0);
         @(negedge clk);
         check_model();
         check("t3_stall_data", W'(down_data_l), W'(1));
         check("t3_stall_last", W'(down_last_l), '0);
         finish_cycle();
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
      check("t3_word_l", got_l, 8'h3C);
      check("t3_word_m", got_m, 8'h3C);
      step(1'b0, '0, 1'b1);

      // Test 4: back-to-back 8'h01 then 8'h80, no bubble.
      step(1'b1, 8'h01, 1'b1);
      for (int i = 0; i < W; i++) step(1'b1, 8'h80, 1'b1);
      check("t4_word1_l", got_l, 8'h01);
      for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1);
      check("t4_word2_l", got_l, 8'h80);
      step(1'b0, '0, 1'b1);

      // Test 5: asynchronous reset after the 4th bit of 8'hFF.
      step(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("t5_async");
      q_l.delete();
      q_m.delete();
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1);
      check("t5_word_l", got_l, 8'h00);
      check("t5_word_m", got_m, 8'h00);
      step(1'b0, '0, 1'b1);

      // Test 6: 8'hAA offered while 8'h55 is mid-word.
      step(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < W - 1; i++) begin
         drive(1'b1, 8'hAA, 1'b1);
         @(negedge clk);
         check_model();
         check("t6_busy_ready", W'(up_ready_l), '0);
         finish_cycle();
      end
      drive(1'b1, 8'hAA, 1'b1);
      @(negedge clk);
      check_model();
      check("t6_last_ready", W'(up_ready_l), W'(1));
      finish_cycle();
      check("t6_word1_l", got_l, 8'h55);
      for (int i = 0; i < W; i++) step(1'b0, '0, 1'b1);
      check("t6_word2_l", got_l, 8'hAA);
      check("t6_word2_m", got_m, 8'hAA);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/word_serializer_mux.md
Name: word_serializer_mux

Overview:
- Parallel-to-serial stage that takes WIDTH-bit words over a valid/ready handshake and emits them one bit per accepted cycle.
- Bit selection is a WIDTH:1 select tree (built from 2:1 mux cells) indexed by a registered bit counter.
- Sits directly upstream of single-bit gate/mux consumers and serial links; feeds them one bit per transfer with a last-bit marker.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 0, 0 = bit 0 emitted first; 1 = bit WIDTH-1 emitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  block can accept a word this cycle.
- up_data  input  WIDTH  upstream word.
- down_valid  output  1  serial bit valid.
- down_ready  input  1  downstream accepts the bit.
- down_data  output  1  current serial bit.
- down_last  output  1  marks the final bit of the current word.

Behaviour:
- Storage: word_reg[WIDTH-1:0]; idx counter of $clog2(WIDTH) bits; state IDLE/SHIFT.
- Reset (async, immediate, not clock-gated):
  - state=IDLE, word_reg=0, idx=0.
  - down_valid=0, down_data=0, down_last=0, up_ready=1.
- up_ready (combinational) = (state==IDLE) || (down_valid && down_ready && down_last). No combinational path from up_valid to up_ready.
- Upstream transfer: up_valid && up_ready at a rising edge.
  - word_reg <= up_data.
  - idx <= 0 if MSB_FIRST=0, else WIDTH-1.
  - state <= SHIFT.
- Latency: first bit is valid the cycle after the upstream transfer.
- Output decode in SHIFT:
  - down_valid=1; down_data=word_reg[idx] via the select tree.
  - down_last=1 when idx is the final index: WIDTH-1 for LSB-first, 0 for MSB-first.
- Downstream transfer: down_valid && down_ready at a rising edge.
  - Not last: idx steps by +1 (LSB-first) or -1 (MSB-first).
  - Last with no new word: state <= IDLE.
  - Last with up_valid=1: the new word loads in the same edge and state stays SHIFT. Back-to-back words produce no bubble, so sustained throughput is 1 word per WIDTH cycles.
- Backpressure: while down_valid && !down_ready, down_data, down_last, idx and word_reg hold stable.
- While in SHIFT and not on the last transfer, up_ready=0. up_data/up_valid are ignored; the upstream must hold its word.
- IDLE outputs: down_valid=0, down_last=0, down_data=0 (masked).
- idx never leaves [0, WIDTH-1]; no wrap is used. Non-power-of-2 WIDTH must never select an out-of-range bit.
- Reset mid-word: the partial word is discarded and no further bits are emitted. After reset deassertion the block is IDLE with up_ready=1.
- down_ready asserted with down_valid=0 has no effect.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, send 8'hA5, down_ready=1 constant.
   - Bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after acceptance.
   - down_last only on the 8th bit; then down_valid=0 and up_ready=1.
2. MSB_FIRST=1, send 8'h0F.
   - Bits 0,0,0,0,1,1,1,1; down_last with the final 1.
3. Send 8'h3C and drop down_ready for 3 cycles after the 2nd bit.
   - down_data/down_last frozen during the stall; the full sequence is 0,0,1,1,1,1,0,0 with no duplicated or lost bit.
4. Back-to-back: hold up_valid with 8'h01 then 8'h80 (LSB-first).
   - 16 consecutive down_valid cycles: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
   - up_ready high only in the initial IDLE cycle and on each last-bit cycle.
5. Assert rst asynchronously, between clock edges, after the 4th bit of 8'hFF.
   - down_valid=0 and up_ready=1 immediately.
   - Next word 8'h00 serializes cleanly as eight 0s, with no leftover bits from 8'hFF.
6. Drive up_valid with 8'hAA while mid-word on 8'h55.
   - up_ready=0 throughout; 8'h55 completes intact; 8'hAA is accepted only on the last-bit cycle.
